// File: rtl/key_db_pkg.sv
// Shared constants for the key debouncer: counter widths and default timing
// for a 50 MHz clock.
package key_db_pkg;

  // Width of the per-channel stability counter (STABLE_CNT is at most 15).
  localparam int STAB_W = 4;

  // Default timing at 50 MHz.
  localparam int TICK_190HZ = 263158;  // clk cycles per sample tick (190 Hz)
  localparam int LONG_1S    = 190;     // ticks of hold for a long press (1 s)
  localparam int REPEAT_5HZ = 38;      // ticks between auto-repeats (5 Hz)

  // Counter widths for the default timing.
  localparam int DIV_W  = $clog2(TICK_190HZ);
  localparam int HOLD_W = $clog2(LONG_1S + 1);

endpackage

// File: rtl/key_db_chan.sv
// One key channel of key_debounce_multi: two-flop synchroniser, tick-driven
// debounce, press/release/long-press strobes.
// Optional feature: KEY_DB_REPEAT_EN adds auto-repeat key_press pulses after
// a long press.
module key_db_chan
  import key_db_pkg::*;
#(
  parameter int ACTIVE_LOW   = 0,
  parameter int STABLE_CNT   = 3,
  parameter int LONG_TICKS   = 190
`ifdef KEY_DB_REPEAT_EN
  ,
  parameter int REPEAT_TICKS = 38
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int   HOLD_BITS = $clog2(LONG_TICKS + 1);
  localparam logic INV       = (ACTIVE_LOW != 0);

  logic                 sync_q1, sync_q2;
  logic                 s;
  logic [STAB_W-1:0]    stab_cnt;
  logic [HOLD_BITS-1:0] hold_cnt;
  logic                 differ, flip;
  logic                 hold_step, hold_sat, long_fire, rep_fire;

  // Two-flop synchroniser; reset loads the pin's idle level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= INV;
      sync_q2 <= INV;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign s      = sync_q2 ^ INV;
  assign differ = s ^ key_level;
  // Level flips on the STABLE_CNT-th consecutive differing sample.
  assign flip   = tick & differ & (stab_cnt == STAB_W'(STABLE_CNT - 1));

  // Ticks while held, excluding the release tick itself.
  assign hold_step = tick & key_level & ~flip;
  assign hold_sat  = (hold_cnt == HOLD_BITS'(LONG_TICKS));
  assign long_fire = hold_step & ~hold_sat & (hold_cnt == HOLD_BITS'(LONG_TICKS - 1));

  // Stability counter: counts differing samples, any agreeing sample restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
    end else if (tick) begin
      if (differ && !flip) stab_cnt <= stab_cnt + 1'b1;
      else                 stab_cnt <= '0;
    end
  end

  // Hold counter: cleared on either level edge, saturates at LONG_TICKS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (flip) begin
      hold_cnt <= '0;
    end else if (hold_step && !hold_sat) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

`ifdef KEY_DB_REPEAT_EN
  logic [HOLD_BITS-1:0] rep_cnt;

  assign rep_fire = hold_step & hold_sat & (rep_cnt == HOLD_BITS'(REPEAT_TICKS - 1));

  // Repeat counter: runs only after key_long, restarts after each repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (flip) begin
      rep_cnt <= '0;
    end else if (hold_step && hold_sat) begin
      rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Debounced level and single-cycle strobes, aligned with the level edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      if (flip) key_level <= ~key_level;
      key_press   <= (flip & ~key_level) | rep_fire;
      key_release <= flip & key_level;
      key_long    <= long_fire;
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: shared sample-tick generator plus one
// key_db_chan per key.
// Optional feature: KEY_DB_REPEAT_EN enables auto-repeat after a long press.
module key_debounce_multi
  import key_db_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int TICK_DIV     = TICK_190HZ,
  parameter int STABLE_CNT   = 3,
  parameter int ACTIVE_LOW   = 0,
  parameter int LONG_TICKS   = LONG_1S,
  parameter int REPEAT_TICKS = REPEAT_5HZ
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic                sample_tick
);

  localparam int DIV_BITS = $clog2(TICK_DIV);

  // Reject configurations the counters cannot represent.
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("TICK_DIV must be >= 2");
  end
  if (STABLE_CNT < 1 || STABLE_CNT > 15) begin : g_bad_stable_cnt
    $error("STABLE_CNT must be in 1..15");
  end
  if (LONG_TICKS < 1) begin : g_bad_long_ticks
    $error("LONG_TICKS must be >= 1");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat_ticks
    $error("REPEAT_TICKS must be >= 1");
  end

  logic [DIV_BITS-1:0] div_cnt;

  // Free-running divider, wraps after TICK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_BITS'(TICK_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign sample_tick = (div_cnt == DIV_BITS'(TICK_DIV - 1));

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_db_chan #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .STABLE_CNT   (STABLE_CNT),
      .LONG_TICKS   (LONG_TICKS)
`ifdef KEY_DB_REPEAT_EN
      ,
      .REPEAT_TICKS (REPEAT_TICKS)
`endif
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (sample_tick),
      .key_raw     (key_in[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed self-checking bench for key_debounce_multi
// (NUM_KEYS=4, TICK_DIV=4, STABLE_CNT=3, LONG_TICKS=8, REPEAT_TICKS=2).
// Expected values adapt to KEY_DB_REPEAT_EN.
module tb_key_debounce_multi;

  localparam int NK       = 4;
  localparam int TICK_DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] key_level, key_press, key_release, key_long;
  logic          sample_tick;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .NUM_KEYS     (NK),
    .TICK_DIV     (TICK_DIV),
    .STABLE_CNT   (3),
    .ACTIVE_LOW   (0),
    .LONG_TICKS   (8),
    .REPEAT_TICKS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .sample_tick (sample_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Strobe monitor: counts high cycles and stamps the tick number of each event.
  int tick_no = 0;
  int press_cnt[NK], release_cnt[NK], long_cnt[NK];
  int first_press[NK], last_press[NK], release_at[NK], long_at[NK];

  always @(negedge clk) begin
    if (sample_tick) tick_no++;
    for (int i = 0; i < NK; i++) begin
      if (key_press[i]) begin
        if (press_cnt[i] == 0) first_press[i] = tick_no;
        last_press[i] = tick_no;
        press_cnt[i]++;
      end
      if (key_release[i]) begin
        release_at[i] = tick_no;
        release_cnt[i]++;
      end
      if (key_long[i]) begin
        long_at[i] = tick_no;
        long_cnt[i]++;
      end
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0;  release_cnt[i] = 0;  long_cnt[i] = 0;
      first_press[i] = -1; last_press[i] = -1; release_at[i] = -1; long_at[i] = -1;
    end
  endtask

  // Returns just after the negedge of the n-th tick cycle from now.
  task automatic wait_ticks(input int n);
    int seen  = 0;
    int guard = 0;
    while (seen < n && guard < n * TICK_DIV * 4 + 8) begin
      @(negedge clk);
      #1;
      if (sample_tick) seen++;
      guard++;
    end
    if (seen < n) check("tick_timeout", seen, n);
  endtask

  int base;
  int cyc;

  initial begin
    clear_mon();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", {key_level, key_press, key_release, key_long, sample_tick}, 0);
    rst_n = 1'b1;

    // Tick period
    wait_ticks(1);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!sample_tick && cyc < 20);
    check("tick_period", cyc, TICK_DIV);

    // 1: clean press on key 0, held 40 clk
    clear_mon();
    wait_ticks(1);
    base = tick_no;
    key_in[0] = 1'b1;
    wait_ticks(10);
    check("t1_press_cnt", press_cnt[0], 1);
    check("t1_press_lat", first_press[0] - base, 3);
    check("t1_level", key_level, 4'b0001);
    check("t1_others", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    key_in[0] = 1'b0;
    base = tick_no;
    wait_ticks(6);
    check("t1_release_cnt", release_cnt[0], 1);
    check("t1_release_lat", release_at[0] - base, 3);
    check("t1_level_off", key_level, 4'b0000);

    // 2: key 1 bounces once per tick, then settles high
    clear_mon();
    wait_ticks(1);
    key_in[1] = 1'b1; wait_ticks(1);
    key_in[1] = 1'b0; wait_ticks(1);
    key_in[1] = 1'b1; wait_ticks(1);
    key_in[1] = 1'b0; wait_ticks(1);
    check("t2_bounce_press", press_cnt[1], 0);
    check("t2_bounce_level", key_level[1], 1'b0);
    key_in[1] = 1'b1;
    base = tick_no;
    wait_ticks(6);
    check("t2_press_cnt", press_cnt[1], 1);
    check("t2_press_lat", first_press[1] - base, 3);
    key_in[1] = 1'b0;
    wait_ticks(6);
    check("t2_release_cnt", release_cnt[1], 1);

    // 3: long press on key 2 (12 ticks), then a 5-tick press
    clear_mon();
    wait_ticks(1);
    base = tick_no;
    key_in[2] = 1'b1;
    wait_ticks(12);
    key_in[2] = 1'b0;
    wait_ticks(6);
    check("t3_press_lat", first_press[2] - base, 3);
    check("t3_long_cnt", long_cnt[2], 1);
    check("t3_long_lat", long_at[2] - first_press[2], 8);
`ifdef KEY_DB_REPEAT_EN
    check("t3_press_cnt", press_cnt[2], 2);
`else
    check("t3_press_cnt", press_cnt[2], 1);
`endif
    check("t3_release_cnt", release_cnt[2], 1);
    clear_mon();
    wait_ticks(1);
    key_in[2] = 1'b1;
    wait_ticks(5);
    key_in[2] = 1'b0;
    wait_ticks(8);
    check("t3_short_press", press_cnt[2], 1);
    check("t3_short_long", long_cnt[2], 0);
    check("t3_short_release", release_cnt[2], 1);

    // 4: keys 0 and 3 together, release key 3 only
    clear_mon();
    wait_ticks(1);
    base = tick_no;
    key_in = 4'b1001;
    wait_ticks(6);
    check("t4_press0", press_cnt[0], 1);
    check("t4_press3", press_cnt[3], 1);
    check("t4_same_cycle", first_press[3], first_press[0]);
    check("t4_press_lat", first_press[3] - base, 3);
    key_in[3] = 1'b0;
    wait_ticks(6);
    check("t4_release3", release_cnt[3], 1);
    check("t4_release0", release_cnt[0], 0);
    check("t4_level", key_level, 4'b0001);
    key_in[0] = 1'b0;
    wait_ticks(6);
    check("t4_level_off", key_level, 4'b0000);

    // 5: reset pulse while key 1 is held
    clear_mon();
    wait_ticks(1);
    key_in[1] = 1'b1;
    wait_ticks(6);
    check("t5_level_pre", key_level[1], 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_async_rst", {key_level, key_press, key_release, key_long, sample_tick}, 0);
    repeat (3) @(negedge clk);
    #1;
    clear_mon();
    tick_no = 0;
    rst_n = 1'b1;
    wait_ticks(6);
    check("t5_repress_cnt", press_cnt[1], 1);
    check("t5_repress_lat", first_press[1], 3);
    check("t5_level_post", key_level, 4'b0010);
    key_in[1] = 1'b0;
    wait_ticks(6);

    // 6: key 0 held 20 ticks (auto-repeat when enabled)
    clear_mon();
    wait_ticks(1);
    base = tick_no;
    key_in[0] = 1'b1;
    wait_ticks(20);
    key_in[0] = 1'b0;
    wait_ticks(6);
    check("t6_long_cnt", long_cnt[0], 1);
    check("t6_long_lat", long_at[0] - first_press[0], 8);
`ifdef KEY_DB_REPEAT_EN
    check("t6_press_cnt", press_cnt[0], 6);
    check("t6_last_repeat", last_press[0] - first_press[0], 18);
`else
    check("t6_press_cnt", press_cnt[0], 1);
    check("t6_last_repeat", last_press[0] - first_press[0], 0);
`endif
    check("t6_release_cnt", release_cnt[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner for the board's key inputs.
- Per channel it synchronises the raw input, debounces it on a shared slow sample tick, and produces:
  - a clean level;
  - single-cycle press and release strobes;
  - a single-cycle long-press strobe.
- Sits between the raw key pins and the control FSMs; replaces the fixed 4-key, press-only debouncer.

Parameters:
- NUM_KEYS, 4: number of independent key channels.
- TICK_DIV, 263158: clk cycles per sample tick (≥2); 263158 gives 190 Hz at 50 MHz.
- STABLE_CNT, 3: consecutive differing samples needed to flip the debounced level (1..15).
- ACTIVE_LOW, 0: 1 means a pressed key reads 0 on key_in; inverted after the synchroniser.
- LONG_TICKS, 190: ticks of continuous press before key_long fires (≥1).
- REPEAT_TICKS, 38: auto-repeat period in ticks; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- key_in  in  NUM_KEYS  raw asynchronous key pins
- key_level  out  NUM_KEYS  debounced level, 1 = pressed
- key_press  out  NUM_KEYS  1-clk strobe on debounced press
- key_release  out  NUM_KEYS  1-clk strobe on debounced release
- key_long  out  NUM_KEYS  1-clk strobe when a press reaches LONG_TICKS
- sample_tick  out  1  1-clk strobe marking each sample instant, for the bench and for other blocks

Behaviour:
- Reset and clock: rst_n asynchronous, active-low; clock clk; all flops on posedge clk.
- Values on reset:
  - Outputs: all outputs 0.
  - Synchroniser: flops load the inactive level.
  - Counters: all 0.
- Synchroniser:
  - Two flops per channel, then ACTIVE_LOW inversion.
  - The synchronised value is called s[i].
- Tick generator:
  - div_cnt counts 0..TICK_DIV-1 and wraps.
  - sample_tick = 1 on the single cycle when div_cnt == TICK_DIV-1.
  - Exactly one tick every TICK_DIV cycles.
- Per-channel debounce, evaluated only on a tick cycle:
  - If s[i] != key_level[i]: stab_cnt increments. When stab_cnt reaches STABLE_CNT-1 on this tick, key_level toggles on the next edge and stab_cnt clears.
  - If s[i] == key_level[i]: stab_cnt clears.
  - Any agreeing sample restarts qualification, so isolated glitch samples never change the level.
  - STABLE_CNT=1 gives single-sample response.
- Strobes:
  - key_press is asserted in the same cycle key_level rises 0→1; key_release in the same cycle it falls 1→0.
  - Each is exactly 1 clk wide.
  - Latency from a stable input change to the strobe is 2 clk (sync) plus up to STABLE_CNT ticks.
- Long press:
  - hold_cnt clears on the press edge and increments on each tick while key_level=1.
  - key_long pulses once, 1 clk, on the tick where hold_cnt reaches LONG_TICKS.
  - hold_cnt then saturates; no further key_long until release.
  - A release clears hold_cnt.
  - A release before LONG_TICKS produces no key_long.
- Channel independence:
  - Channels are fully independent; any combination of strobes may be asserted in the same cycle.
- Reset mid-press:
  - All state returns to idle.
  - A key still held after reset is requalified and produces a fresh key_press.
- Counter widths: stab_cnt 4 bits, hold_cnt and repeat counter $clog2(LONG_TICKS+1) bits, div_cnt $clog2(TICK_DIV) bits.

Optional Feature:
- Macro: KEY_DB_REPEAT_EN.
- Defined:
  - After key_long fires, key_press additionally pulses every REPEAT_TICKS ticks while the key stays pressed.
  - The first repeat comes REPEAT_TICKS ticks after key_long.
  - A per-channel repeat counter clears on release.
- Undefined: no repeat logic is generated; key_press fires only on the press edge.

Decomposition:
- Package key_db_pkg:
  - width helper constants: DIV_W, HOLD_W, STAB_W;
  - default timing constants for 50 MHz: TICK_190HZ, LONG_1S, REPEAT_5HZ.
- Sub-module key_db_chan: one channel containing the synchroniser, stab_cnt, level, hold/repeat counters and strobes.
  - The top instantiates NUM_KEYS copies with a generate loop and owns the single tick generator.

Test Plan:
All scenarios use NUM_KEYS=4, TICK_DIV=4, STABLE_CNT=3, LONG_TICKS=8, REPEAT_TICKS=2.
1. Clean press on key 0, held 40 clk → key_level[0] rises within 3 ticks + 2 clk; key_press[0] exactly one 1-clk pulse; other channels stay 0.
2. Key 1 bounces 1,0,1,0 toggling every tick, then stable 1 → no level change during the bounce; one key_press 3 ticks after stability; release gives one key_release.
3. Key 2 held 12 ticks → key_long[2] exactly once, 8 ticks after key_press; no key_long on a 5-tick press.
4. Keys 0 and 3 pressed in the same cycle → simultaneous key_press[0] and key_press[3]; key 3 released while key 0 held → key_release[3] only.
5. rst_n pulsed low mid-hold on key 1 → outputs 0 immediately (async); after release of reset, key_press[1] fires again after requalification.
6. With KEY_DB_REPEAT_EN, key 0 held 20 ticks → key_press at the edge, key_long at tick 8, repeats at ticks 10, 12, 14, …; without the macro, only the edge press.
